bram_port_requester: RTL

//  Single-outstanding bus master driving one BRAM port (addr/in/select/write/strobe, ack/retry/out).

---
 rtl/bram_port_requester.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bram_port_requester.sv
// bram_port_requester
//   Single-outstanding bus master for one BRAM port. Accepts one core request
//   on a valid/ready channel, drives a one-cycle strobe to the RAM, reissues
//   the access when the RAM answers retry, bounds the wait for ack/retry with
//   a timeout, and returns exactly one response per accepted request.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
//   where valid and ready are both high. rsp_valid, rsp_data and rsp_error
//   are held stable until that transfer; req_ready is high only in IDLE.
//
// Ports
//   clock, reset              clock (rising edge), synchronous active-low reset
//   req_valid/req_ready       core request handshake
//   req_addr/req_data         word address and write data
//   req_select/req_write      byte-lane enables, 1 = write
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_error        read data, 1 = retries exhausted or timeout
//   mem_addr/mem_in           RAM address and write data
//   mem_select/mem_write      RAM byte enables and write flag
//   mem_strobe                RAM access strobe, one-cycle pulses
//   mem_ack/mem_retry         RAM completion / busy-retry
//   mem_out                   RAM read data, valid with mem_ack
//   dbg_state                 current FSM state (IDLE=0 ISSUE=1 WAIT=2 RESP=3)
module bram_port_requester #(
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned BYTE_BITS      = 8,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT        = 15,
  localparam int unsigned WORD_BITS     = BYTE_BITS * BYTES_PER_WORD
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_BITS-1:0]      req_addr,
  input  logic [WORD_BITS-1:0]      req_data,
  input  logic [BYTES_PER_WORD-1:0] req_select,
  input  logic                      req_write,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WORD_BITS-1:0]      rsp_data,
  output logic                      rsp_error,
  output logic [ADDR_BITS-1:0]      mem_addr,
  output logic [WORD_BITS-1:0]      mem_in,
  output logic [BYTES_PER_WORD-1:0] mem_select,
  output logic                      mem_write,
  output logic                      mem_strobe,
  input  logic                      mem_ack,
  input  logic                      mem_retry,
  input  logic [WORD_BITS-1:0]      mem_out,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRIES);
  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);

  state_t                    state, state_next;
  logic [7:0]                retry_cnt, retry_cnt_next;
  logic [7:0]                wait_cnt, wait_cnt_next;
  logic [ADDR_BITS-1:0]      addr_q, addr_next;
  logic [WORD_BITS-1:0]      data_q, data_next;
  logic [BYTES_PER_WORD-1:0] select_q, select_next;
  logic                      write_q, write_next;
  logic [WORD_BITS-1:0]      rdata_q, rdata_next;
  logic                      error_q, error_next;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      retry_cnt <= '0;
      wait_cnt  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      select_q  <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_next;
      retry_cnt <= retry_cnt_next;
      wait_cnt  <= wait_cnt_next;
      addr_q    <= addr_next;
      data_q    <= data_next;
      select_q  <= select_next;
      write_q   <= write_next;
      rdata_q   <= rdata_next;
      error_q   <= error_next;
    end
  end

  always_comb begin
    state_next     = state;
    retry_cnt_next = retry_cnt;
    wait_cnt_next  = wait_cnt;
    addr_next      = addr_q;
    data_next      = data_q;
    select_next    = select_q;
    write_next     = write_q;
    rdata_next     = rdata_q;
    error_next     = error_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_next      = req_addr;
          data_next      = req_data;
          select_next    = req_select;
          write_next     = req_write;
          retry_cnt_next = '0;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_next = '0;
        state_next    = WAIT;
      end
      WAIT: begin
        // ack outranks retry when both arrive in the same cycle.
        if (mem_ack) begin
          rdata_next = mem_out;
          error_next = 1'b0;
          state_next = RESP;
        end else if (mem_retry) begin
          if (retry_cnt == RETRY_LIMIT) begin
            rdata_next = '0;
            error_next = 1'b1;
            state_next = RESP;
          end else begin
            retry_cnt_next = retry_cnt + 8'd1;
            state_next     = ISSUE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          rdata_next = '0;
          error_next = 1'b1;
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and strobe outputs decode straight from state, so ack/retry
  // seen outside WAIT can never reach the response path.
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign mem_strobe = (state == ISSUE);
  assign rsp_data   = rdata_q;
  assign rsp_error  = error_q;
  assign mem_addr   = addr_q;
  assign mem_in     = data_q;
  assign mem_select = select_q;
  assign mem_write  = write_q;
  assign dbg_state  = state;

endmodule
